// File: rtl/display_color_encoder_pipelined.sv
// -----------------------------------------------------------------------------
// display_color_encoder_pipelined
//
// Colour encoder for the HUB75 display controller. It takes one parallel word
// of per-segment pixels plus a modulation slot ("cycle") and produces one RGB
// bit per channel for that slot. The encoder sits between the framebuffer
// reader and the row shifter. Both sides use a valid/ready handshake.
//
//   mode 0 : PWM threshold. bit = (ch == all-ones) || (ch > cycle)
//   mode 1 : BCM bit-plane. bit = ch[cycle mod depth]
//
// Pipeline: S1 registers pixel/cycle, and S2 registers the encoded rgb.
// Latency is 2 clocks and the encoder accepts one beat per clock. A stage
// loads whenever it is empty or its successor is loading, so bubbles compact.
//
// Optional build macro DISPLAY_ENCODER_GAMMA_EN adds a gamma stage S1b between
// S1 and S2, which gives a latency of 3. In that build every channel is
// replaced by g = (ch*ch) >> depth before the compare or select. The mode-0
// full-scale force-on still looks at the original channel value.
//
// Ports
//   clk        in   1                 system clock, rising edge
//   rst_n      in   1                 asynchronous active-low reset
//   pixel      in   segments*3*depth  segment s at [s*3*depth +: 3*depth], {R,G,B}
//   cycle      in   depth             PWM threshold / bit-plane index
//   in_valid   in   1                 pixel/cycle valid
//   in_ready   out  1                 encoder accepts this cycle (combinational)
//   rgb        out  segments*3        segment s at [s*3 +: 3], {R,G,B}
//   out_valid  out  1                 rgb valid
//   out_ready  in   1                 downstream accepts rgb
// -----------------------------------------------------------------------------
module display_color_encoder_pipelined #(
  parameter int segments = 2,
  parameter int depth    = 8,
  parameter int mode     = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [segments*3*depth-1:0]  pixel,
  input  logic [depth-1:0]             cycle,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [segments*3-1:0]        rgb,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int pix_w = segments * 3 * depth;
  localparam int rgb_w = segments * 3;
  localparam int idx_w = $clog2(depth);
  localparam logic [depth-1:0] depth_c = depth[depth-1:0];

  // Channel k of the pixel word sits at [k*depth +: depth], and its output
  // bit is rgb[k]. Within a segment, k = s*3 + {2:R, 1:G, 0:B}. This keeps
  // the segment order and the colour order without any reshuffling.

  // Bit-plane index. The modulo wraps out-of-range slots to a valid plane,
  // so the select never reads outside the channel.
  function automatic logic [idx_w-1:0] plane_of(input logic [depth-1:0] cyc);
    logic [depth-1:0] rem;
    rem = cyc % depth_c;
    return rem[idx_w-1:0];
  endfunction

  function automatic logic enc_bit(input logic [depth-1:0] ch,
                                   input logic             full,
                                   input logic [depth-1:0] cyc);
    logic b;
    if (mode == 0) b = full || (ch > cyc);
    else           b = ch[plane_of(cyc)];
    return b;
  endfunction

  // ---------------------------------------------------------------------------
  // Handshake: each stage loads when it is empty or its successor loads.
  // ---------------------------------------------------------------------------
  logic             s1_valid;
  logic [pix_w-1:0] s1_pixel;
  logic [depth-1:0] s1_cycle;
  logic             s1_ld;
  logic             s2_ld;

  // Signals feeding the encoder (S1 directly, or S1b in the gamma build).
  logic             src_valid;
  logic [pix_w-1:0] src_chan;
  logic [rgb_w-1:0] src_full;
  logic [depth-1:0] src_cycle;
  logic [rgb_w-1:0] enc_rgb;

  assign s2_ld    = !out_valid || out_ready;
  assign in_ready = s1_ld;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours; blocking here would let a beat
  // ripple through several stages in one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s1_valid <= 1'b0;
    else if (s1_ld) s1_valid <= in_valid;
  end

  // NOTE: payload registers carry no reset. They are only ever observed
  // behind their stage valid bit, which is reset, so leaving them unreset
  // is safe and keeps the reset tree small.
  always_ff @(posedge clk) begin
    if (s1_ld && in_valid) begin
      s1_pixel <= pixel;
      s1_cycle <= cycle;
    end
  end

`ifdef DISPLAY_ENCODER_GAMMA_EN
  // ---------------------------------------------------------------------------
  // Gamma stage S1b. The full-scale flag is taken from the raw channel because
  // the square maps all-ones to all-ones minus one.
  // ---------------------------------------------------------------------------
  function automatic logic [depth-1:0] gamma(input logic [depth-1:0] ch);
    logic [2*depth-1:0] sq;
    sq = {{depth{1'b0}}, ch} * {{depth{1'b0}}, ch};
    return sq[2*depth-1:depth];
  endfunction

  logic             sb_valid;
  logic [pix_w-1:0] sb_chan;
  logic [rgb_w-1:0] sb_full;
  logic [depth-1:0] sb_cycle;
  logic [pix_w-1:0] gam_chan;
  logic [rgb_w-1:0] gam_full;
  logic             sb_ld;

  assign sb_ld = !sb_valid || s2_ld;
  assign s1_ld = !s1_valid || sb_ld;

  // NOTE: every signal driven by an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    gam_chan = '0;
    gam_full = '0;
    for (int k = 0; k < rgb_w; k++) begin
      gam_full[k]                = &s1_pixel[k*depth +: depth];
      gam_chan[k*depth +: depth] = gamma(s1_pixel[k*depth +: depth]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sb_valid <= 1'b0;
    else if (sb_ld) sb_valid <= s1_valid;
  end

  always_ff @(posedge clk) begin
    if (sb_ld && s1_valid) begin
      sb_chan  <= gam_chan;
      sb_full  <= gam_full;
      sb_cycle <= s1_cycle;
    end
  end

  assign src_valid = sb_valid;
  assign src_chan  = sb_chan;
  assign src_full  = sb_full;
  assign src_cycle = sb_cycle;
`else
  assign s1_ld = !s1_valid || s2_ld;

  always_comb begin
    src_full = '0;
    for (int k = 0; k < rgb_w; k++) begin
      src_full[k] = &s1_pixel[k*depth +: depth];
    end
  end

  assign src_valid = s1_valid;
  assign src_chan  = s1_pixel;
  assign src_cycle = s1_cycle;
`endif

  // ---------------------------------------------------------------------------
  // Encoder and output stage S2
  // ---------------------------------------------------------------------------
  always_comb begin
    enc_rgb = '0;
    for (int k = 0; k < rgb_w; k++) begin
      enc_rgb[k] = enc_bit(src_chan[k*depth +: depth], src_full[k], src_cycle);
    end
  end

  // rgb is reset with out_valid so the output reads zero as soon as reset
  // asserts. While S2 is stalled, both registers hold their values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      rgb       <= '0;
    end else if (s2_ld) begin
      out_valid <= src_valid;
      if (src_valid) rgb <= enc_rgb;
    end
  end

endmodule

// File: tb/tb_display_color_encoder_pipelined.sv
// -----------------------------------------------------------------------------
// Testbench for display_color_encoder_pipelined (segments=2, depth=8).
// Two instances share the stimulus: one in PWM mode and one in BCM mode.
// Each accepted beat pushes the expected rgb of both instances onto a
// scoreboard. A monitor pops that entry when the output transfers.
// -----------------------------------------------------------------------------
module tb_display_color_encoder_pipelined;

`ifdef DISPLAY_ENCODER_GAMMA_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk;
  logic        rst_n;
  logic [47:0] pixel;
  logic [7:0]  cycle;
  logic        in_valid;
  logic        out_ready;
  logic        in_ready_p, in_ready_b;
  logic [5:0]  rgb_p, rgb_b;
  logic        ov_p, ov_b;

  int n_cmp = 0;
  int n_bad = 0;
  int clk_cnt = 0;

  typedef struct {
    logic [5:0] exp_p;
    logic [5:0] exp_b;
  } beat_t;
  beat_t sb_q[$];

  display_color_encoder_pipelined #(.segments(2), .depth(8), .mode(0)) u_dut_pwm (
    .clk(clk), .rst_n(rst_n), .pixel(pixel), .cycle(cycle),
    .in_valid(in_valid), .in_ready(in_ready_p),
    .rgb(rgb_p), .out_valid(ov_p), .out_ready(out_ready)
  );

  display_color_encoder_pipelined #(.segments(2), .depth(8), .mode(1)) u_dut_bcm (
    .clk(clk), .rst_n(rst_n), .pixel(pixel), .cycle(cycle),
    .in_valid(in_valid), .in_ready(in_ready_b),
    .rgb(rgb_b), .out_valid(ov_b), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) clk_cnt <= clk_cnt + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model written per named colour: R, G and B of each segment.
  function automatic logic [5:0] model(input logic [47:0] pix, input logic [7:0] cyc, input bit bcm);
    logic [5:0]  r;
    logic [7:0]  ch, g;
    logic [15:0] sq;
    int          plane;
    r = '0;
    plane = int'(cyc) % 8;
    for (int s = 0; s < 2; s++) begin
      for (int c = 0; c < 3; c++) begin        // c: 0=R 1=G 2=B
        ch = pix[s*24 + (2-c)*8 +: 8];
        sq = 16'(ch) * 16'(ch);
`ifdef DISPLAY_ENCODER_GAMMA_EN
        g = sq[15:8];
`else
        g = ch;
`endif
        r[s*3 + (2-c)] = bcm ? g[plane] : ((ch == 8'hff) || (g > cyc));
      end
    end
    return r;
  endfunction

  function automatic void push(input logic [47:0] pix, input logic [7:0] cyc);
    beat_t b;
    b.exp_p = model(pix, cyc, 1'b0);
    b.exp_b = model(pix, cyc, 1'b1);
    sb_q.push_back(b);
  endfunction

  // Monitor: compare every output transfer against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ov_p === 1'b1 && out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("stray_beat", 32'(ov_p), 32'd0);
      end else begin
        beat_t b;
        b = sb_q.pop_front();
        check("rgb_pwm", 32'(rgb_p), 32'(b.exp_p));
        check("rgb_bcm", 32'(rgb_b), 32'(b.exp_b));
        check("valid_bcm", 32'(ov_b), 32'd1);
      end
    end
  end

  // Present one beat and hold it until it is accepted (bounded).
  task automatic drive(input logic [47:0] pix, input logic [7:0] cyc);
    int  n = 0;
    bit  done = 0;
    pixel = pix;
    cycle = cyc;
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready_p) begin
        push(pix, cyc);
        done = 1;
      end else if (++n > 50) begin
        check("accept_timeout", 32'(in_ready_p), 32'd1);
        done = 1;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", 32'(sb_q.size()), 32'd0);
  endtask

  // Send a single beat into an empty pipeline and measure the latency.
  task automatic lat_check(input logic [47:0] pix, input logic [7:0] cyc);
    int cyc_a;
    bit seen = 0;
    pixel = pix;
    cycle = cyc;
    in_valid = 1'b1;
    @(negedge clk);
    check("lat_in_ready", 32'(in_ready_p), 32'd1);
    cyc_a = clk_cnt;
    push(pix, cyc);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (ov_p) seen = 1;
    end
    check("latency", 32'(clk_cnt - cyc_a), 32'(LAT));
    @(posedge clk); #1;
  endtask

  initial begin
    bit drv_done;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    pixel     = '0;
    cycle     = '0;
    out_ready = 1'b1;

    // Reset state
    #1;
    check("rst_ov_pwm", 32'(ov_p), 32'd0);
    check("rst_rgb_pwm", 32'(rgb_p), 32'd0);
    check("rst_ov_bcm", 32'(ov_b), 32'd0);
    check("rst_rgb_bcm", 32'(rgb_b), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_in_ready", 32'(in_ready_p), 32'd1);
    check("rel_ov", 32'(ov_p), 32'd0);

    // Test 1: all-zero segment 1 and full-scale segment 0, cycle swept 0..255
    lat_check({24'h000000, 24'hffffff}, 8'd0);
    for (int c = 1; c < 256; c++) drive({24'h000000, 24'hffffff}, 8'(c));
    drain();

    // Test 2: threshold boundary 7f / 80
    lat_check({24'h000000, 24'h80ff00}, 8'h7f);
    drive({24'h000000, 24'h80ff00}, 8'h80);
    drain();

    // Test 3: bit-plane walk of R=A5, including wrapped slots
    for (int c = 0; c < 8; c++) drive({24'h000000, 24'ha50000}, 8'(c));
    drive({24'h000000, 24'ha50000}, 8'd9);
    drive({24'h000000, 24'ha50000}, 8'hff);
    drain();

    // Test 4: 8-beat stream with a 3-clock output stall mid-stream
    fork
      begin
        for (int i = 0; i < 8; i++)
          drive({8'(i*17), 8'(i*29), 8'(255-i*31), 8'(i*53), 8'(i*7+3), 8'(200-i)}, 8'(i*32));
        in_valid = 1'b0;
      end
      begin
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
          @(negedge clk);
          if (ov_p) seen = 1;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("hold_valid", 32'(ov_p), 32'd1);
          if (sb_q.size() > 0) begin
            check("hold_rgb_pwm", 32'(rgb_p), 32'(sb_q[0].exp_p));
            check("hold_rgb_bcm", 32'(rgb_b), 32'(sb_q[0].exp_b));
          end else begin
            check("hold_queue", 32'(sb_q.size()), 32'd1);
          end
        end
        check("stall_in_ready", 32'(in_ready_p), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Test 5: reset while two beats are in flight
    drive({24'h000000, 24'hffffff}, 8'd10);
    drive({24'hffffff, 24'h000000}, 8'd20);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_ov_pwm", 32'(ov_p), 32'd0);
    check("midrst_rgb_pwm", 32'(rgb_p), 32'd0);
    check("midrst_ov_bcm", 32'(ov_b), 32'd0);
    check("midrst_rgb_bcm", 32'(rgb_b), 32'd0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_in_ready", 32'(in_ready_p), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_stale", 32'(ov_p), 32'd0);
    end
    @(posedge clk); #1;

    // Test 6: R=80 around the gamma knee (raw channel in the default build)
    lat_check({24'h000000, 24'h800000}, 8'h3f);
    lat_check({24'h000000, 24'h800000}, 8'h40);

    // Random beats with random backpressure
    drv_done = 0;
    fork
      begin
        for (int i = 0; i < 40; i++)
          drive({$urandom, 16'($urandom)}, 8'($urandom_range(0, 255)));
        in_valid = 1'b0;
        drv_done = 1;
      end
      begin
        while (!drv_done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
